// File: rtl/crc32_pkg.sv
// Shared CRC-32 constants, FCS appender state type and bit-reversal helpers.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    typedef enum logic {
        ST_DATA,
        ST_FCS
    } state_e;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/crc32_byte_lfsr.sv
// Combinational CRC-32 LFSR advance by one byte, data[7] shifted in first.
module crc32_byte_lfsr
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] w_crc;
    logic        w_fb;

    always_comb begin
        w_crc = crc_in;
        w_fb  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            w_fb  = w_crc[31] ^ data[i];
            w_crc = {w_crc[30:0], 1'b0};
            if (w_fb) w_crc = w_crc ^ CRC32_POLY;
        end
        crc_next = w_crc;
    end

endmodule

// File: rtl/crc32_fcs_appender.sv
// Byte-stream pass-through that appends a 4-byte CRC-32 FCS after each frame.
// Optional frame counter enabled by defining CRC32_FRAME_CNT_EN.
//
// state   | meaning
// ST_DATA | payload passes straight through, LFSR accumulates accepted bytes
// ST_FCS  | upstream held off, fcs_reg emitted one byte per accepted beat
module crc32_fcs_appender
    import crc32_pkg::*;
#(
    parameter bit REFLECT = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic             crc_busy,
    output logic [CNT_W-1:0] frame_cnt
);

    state_e      r_state;
    logic [31:0] r_lfsr;
    logic [31:0] r_fcs;
    logic [1:0]  r_idx;
    logic        r_crc_busy;

    logic [7:0]  w_data_in;
    logic [31:0] w_lfsr_next;
    logic [31:0] w_fcs_final;
    logic [1:0]  w_fcs_sel;
    logic [7:0]  w_fcs_byte;
    logic        w_acc_data;
    logic        w_acc_fcs;
    logic        w_frame_done;

    assign w_data_in = REFLECT ? bitrev8(s_tdata) : s_tdata;

    crc32_byte_lfsr u_lfsr (
        .crc_in   (r_lfsr),
        .data     (w_data_in),
        .crc_next (w_lfsr_next)
    );

    // The last payload byte is folded in before the final transform.
    assign w_fcs_final = REFLECT ? (bitrev32(w_lfsr_next) ^ CRC32_XOROUT)
                                 : (w_lfsr_next ^ CRC32_XOROUT);

    // Reflected FCS goes out LSB byte first, non-reflected MSB byte first.
    assign w_fcs_sel = REFLECT ? r_idx : ~r_idx;

    always_comb begin
        w_fcs_byte = r_fcs[7:0];
        case (w_fcs_sel)
            2'd0: w_fcs_byte = r_fcs[7:0];
            2'd1: w_fcs_byte = r_fcs[15:8];
            2'd2: w_fcs_byte = r_fcs[23:16];
            2'd3: w_fcs_byte = r_fcs[31:24];
            default: w_fcs_byte = r_fcs[7:0];
        endcase
    end

    assign w_acc_data   = (r_state == ST_DATA) && s_tvalid && m_tready;
    assign w_acc_fcs    = (r_state == ST_FCS) && m_tready;
    assign w_frame_done = w_acc_fcs && (r_idx == 2'd3);

    assign s_tready = (r_state == ST_DATA) && m_tready;
    assign m_tvalid = (r_state == ST_DATA) ? s_tvalid : 1'b1;
    assign m_tdata  = (r_state == ST_DATA) ? s_tdata : w_fcs_byte;
    assign m_tlast  = (r_state == ST_FCS) && (r_idx == 2'd3);
    assign crc_busy = r_crc_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_DATA;
            r_lfsr     <= CRC32_INIT;
            r_fcs      <= 32'h0;
            r_idx      <= 2'd0;
            r_crc_busy <= 1'b0;
        end else if (r_state == ST_DATA) begin
            if (w_acc_data) begin
                r_lfsr <= w_lfsr_next;
                if (s_tlast) begin
                    r_fcs      <= w_fcs_final;
                    r_idx      <= 2'd0;
                    r_state    <= ST_FCS;
                    r_crc_busy <= 1'b1;
                end
            end
        end else if (w_acc_fcs) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                r_state    <= ST_DATA;
                r_lfsr     <= CRC32_INIT;
                r_crc_busy <= 1'b0;
            end
        end
    end

`ifdef CRC32_FRAME_CNT_EN
    logic [CNT_W-1:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    logic w_unused_done;
    assign w_unused_done = w_frame_done;
    assign frame_cnt     = '0;
`endif

endmodule

// File: doc/crc32_fcs_appender.md
Name: crc32_fcs_appender

Overview:
- Byte-stream stage that passes frame payload bytes through unchanged and appends a 4-byte CRC-32 frame check sequence (FCS) after each frame's last byte.
- Sits directly upstream of the TTC framer/serializer and computes the CRC byte-parallel with an internal CRC-32 LFSR.
- The LFSR uses polynomial 0x04C11DB7, seed all-ones, one byte per cycle, data_in[7] shifted first.

Parameters:
- REFLECT, 1, selects the CRC-32 bit order:
  - 1: standard IEEE CRC-32. Bytes are bit-reversed into the LFSR. FCS = ~bitrev32(lfsr). FCS is sent LSB byte first.
  - 0: MSB-first CRC-32. Bytes are fed as-is. FCS = ~lfsr. FCS is sent MSB byte first.
- CNT_W, 16, width of the frame counter (only used with CRC32_FRAME_CNT_EN).

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- s_tdata  input  8  payload byte
- s_tvalid  input  1  payload byte valid
- s_tlast  input  1  last payload byte of the frame
- s_tready  output  1  stage accepts a payload byte
- m_tdata  output  8  output byte (payload or FCS)
- m_tvalid  output  1  output byte valid
- m_tlast  output  1  final FCS byte of the frame
- m_tready  input  1  downstream accepts a byte
- crc_busy  output  1  high while the FCS is being emitted
- frame_cnt  output  CNT_W  completed frames (only with CRC32_FRAME_CNT_EN)

Behaviour:
- Handshake: a transfer occurs when valid and ready are both high on a rising clk edge. m_tvalid never drops before acceptance. m_tdata and m_tlast are held stable while stalled.
- States: DATA and FCS. Reset state is DATA.
- Reset values: lfsr = 32'hFFFFFFFF, fcs_reg = 0, byte index = 0, crc_busy = 0, frame_cnt = 0.
- DATA state, pass-through (zero latency, combinational):
  - m_tdata = s_tdata, m_tvalid = s_tvalid, s_tready = m_tready.
  - m_tlast = 0 always; s_tlast is absorbed.
- On each accepted payload byte: lfsr <= lfsr_next(byte).
- On an accepted byte with s_tlast = 1:
  - fcs_reg <= final transform of lfsr_next(byte); the last byte is included.
  - Byte index <= 0, state -> FCS.
- FCS state:
  - s_tready = 0 and crc_busy = 1.
  - m_tvalid = 1 and m_tdata = fcs_reg byte[idx], in the byte order set by REFLECT.
  - m_tlast = 1 when idx == 3.
  - idx increments on each accepted FCS byte.
  - On acceptance at idx == 3: state -> DATA, lfsr <= 32'hFFFFFFFF (synchronous reseed), frame_cnt increments.
- Back-pressure: m_tready = 0 freezes every register.
- Zero-length frames are not supported: every frame carries at least one payload byte.
- No idle gap: the first payload byte of the next frame is accepted the cycle after the final FCS byte is accepted.
- Reset asserted mid-frame or mid-FCS: immediate return to DATA with an all-ones LFSR. The partial frame is dropped downstream by the framer; no recovery is attempted here.
- Throughput: 1 byte/clk during payload. Each frame adds exactly 4 cycles of FCS when m_tready stays high.

Optional Feature:
- Macro: CRC32_FRAME_CNT_EN.
- Defined:
  - frame_cnt is a CNT_W-bit counter.
  - Increments on acceptance of each final FCS byte.
  - Wraps from all-ones to 0.
  - Reset to 0.
- Undefined: frame_cnt is tied to 0 and no counter flops are generated.

Decomposition:
- Shared package crc32_pkg holds:
  - CRC32_POLY = 32'h04C11DB7, CRC32_INIT = 32'hFFFFFFFF, CRC32_XOROUT = 32'hFFFFFFFF.
  - State enum {ST_DATA, ST_FCS}.
  - Functions bitrev8 and bitrev32.
- Sub-module crc32_byte_lfsr: purely combinational next-state function (crc_in[31:0], data[7:0] -> crc_next[31:0]). It is instantiated once; the FSM, counters and muxing stay in the top module.

Test Plan:
- REFLECT=1, frame "123456789" (31 32 … 39), m_tready = 1 -> payload unchanged, then FCS bytes 26 39 F4 CB. m_tlast on CB only. Total 13 cycles.
- REFLECT=1, single byte 0x00 with s_tlast -> output 00, 8D, EF, 02, D2. m_tlast on D2.
- Back-to-back frames "123456789" then 0x00 -> the second FCS is D202EF8D, proving the reseed. No bubble between the CB byte and the first byte of frame two.
- Random m_tready stalls (about 50%) during payload and during FCS on "123456789" -> identical byte sequence. m_tdata and m_tlast are stable while stalled. s_tready stays 0 throughout FCS.
- rst pulsed after 5 payload bytes, then full "123456789" sent -> FCS 26 39 F4 CB; no pre-reset contribution.
- With CRC32_FRAME_CNT_EN and CNT_W = 4, 17 frames sent -> frame_cnt reads 1 (wrap). Without the macro, frame_cnt = 0 throughout.
